// File: rtl/alu_serial.sv
// Digit-serial 32-bit ALU: one DIGIT_W-bit slice per RUN cycle, LSB first,
// with a valid/ready handshake on both the request and the result side.
module alu_serial #(
    parameter  int DIGIT_W = 4,
    localparam int N       = 32 / DIGIT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  alu_control,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_result,
    output logic        zero
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]        a_reg;
    logic [31:0]        b_reg;
    logic [2:0]         op_reg;
    logic [KW-1:0]      k;
    logic               carry;
    logic [31:0]        res_acc;

    logic [5:0]         bit_pos;
    logic               last_digit;
    logic [DIGIT_W-1:0] a_d;
    logic [DIGIT_W-1:0] b_d;
    logic [DIGIT_W-1:0] b_op;
    logic               is_sub;
    logic               cin;
    logic [DIGIT_W:0]   sum;
    logic [DIGIT_W-1:0] res_digit;
    logic               s31;
    logic               a31;
    logic               b31;
    logic               ovf;
    logic               lt;
    logic [31:0]        merged;
    logic [31:0]        final_word;

    assign bit_pos    = 6'(k) * 6'(DIGIT_W);
    assign last_digit = (k == KW'(N - 1));
    assign a_d        = a_reg[bit_pos +: DIGIT_W];
    assign b_d        = b_reg[bit_pos +: DIGIT_W];

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)   state_next = RUN;
            RUN:  if (last_digit) state_next = DONE;
            DONE: if (out_ready)  state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    // Sub and slt share the adder as A + ~B + 1; the 1 enters only on digit 0.
    always_comb begin
        is_sub = (op_reg == OP_SUB) || (op_reg == OP_SLT);
        b_op   = is_sub ? ~b_d : b_d;
        cin    = (k == '0) ? is_sub : carry;
        sum    = {1'b0, a_d} + {1'b0, b_op} + {{DIGIT_W{1'b0}}, cin};
        case (op_reg)
            OP_AND:  res_digit = a_d & b_d;
            OP_OR:   res_digit = a_d | b_d;
            default: res_digit = sum[DIGIT_W-1:0];
        endcase
    end

    // Signed less-than is derived from the top digit of the difference.
    always_comb begin
        s31 = sum[DIGIT_W-1];
        a31 = a_d[DIGIT_W-1];
        b31 = b_d[DIGIT_W-1];
        ovf = (a31 == ~b31) && (s31 != a31);
        lt  = s31 ^ ovf;
        merged = res_acc;
        merged[bit_pos +: DIGIT_W] = res_digit;
        final_word = (op_reg == OP_SLT) ? {31'b0, lt} : merged;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            k          <= '0;
            carry      <= 1'b0;
            res_acc    <= '0;
            alu_result <= '0;
            zero       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= src_a;
                        b_reg  <= src_b;
                        op_reg <= alu_control;
                        k      <= '0;
                        carry  <= 1'b0;
                    end
                end
                RUN: begin
                    res_acc <= merged;
                    carry   <= sum[DIGIT_W];
                    if (last_digit) begin
                        k          <= '0;
                        alu_result <= final_word;
                        zero       <= (final_word == 32'd0);
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// Randomised self-checking bench for alu_serial against a plain-arithmetic
// model of the ALU operations, plus directed corner cases and reset checks.
module tb_alu_serial;

    localparam int DIGIT_W = 4;
    localparam int N       = 32 / DIGIT_W;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic        zero;

    int errors;
    int checks;
    logic [31:0] last_result;

    alu_serial #(.DIGIT_W(DIGIT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_alu(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_result", alu_result, 32'd0);
        checkOutput("rst_zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_idle", 32'(in_ready), 32'd1);
        last_result = 32'd0;
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int hold);
        logic [31:0] expv;
        int cycles;
        bit seen;
        expv = model_alu(op, a, b);
        @(negedge clk);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        alu_control = op;
        src_a       = a;
        src_b       = b;
        out_ready   = 1'($urandom);
        @(posedge clk);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 4 * N + 8) begin
            @(negedge clk);
            in_valid    = 1'($urandom);
            alu_control = 3'($urandom);
            src_a       = $urandom;
            src_b       = $urandom;
            out_ready   = 1'($urandom);
            @(posedge clk);
            #1;
            cycles++;
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                checkOutput("run_in_ready", 32'(in_ready), 32'd0);
                checkOutput("run_hold_result", alu_result, last_result);
            end
        end
        checkOutput("latency", 32'(cycles), 32'(N));
        if (!seen) begin
            doReset();
            return;
        end
        checkOutput("result", alu_result, expv);
        checkOutput("zero", 32'(zero), 32'(expv == 32'd0));
        checkOutput("done_in_ready", 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            src_a     = $urandom;
            src_b     = $urandom;
            @(posedge clk);
            #1;
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_result", alu_result, expv);
            checkOutput("hold_zero", 32'(zero), 32'(expv == 32'd0));
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("consume_out_valid", 32'(out_valid), 32'd0);
        checkOutput("consume_in_ready", 32'(in_ready), 32'd1);
        checkOutput("consume_result", alu_result, expv);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        last_result = expv;
    endtask

    task automatic resetMidRun();
        @(negedge clk);
        in_valid    = 1'b1;
        alu_control = 3'b000;
        src_a       = 32'h1234_5678;
        src_b       = 32'h1111_1111;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrun_busy", 32'(in_ready), 32'd0);
        doReset();
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        last_result = 32'd0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        alu_control = 3'b000;
        src_a       = 32'd0;
        src_b       = 32'd0;
        repeat (2) @(posedge clk);
        doReset();

        applyStimulus(3'b000, 32'd5, 32'd7, 0);
        applyStimulus(3'b001, 32'd3, 32'd3, 1);
        applyStimulus(3'b001, 32'd0, 32'd1, 0);
        applyStimulus(3'b101, 32'hFFFF_FFFF, 32'd1, 0);
        applyStimulus(3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        applyStimulus(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        applyStimulus(3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        applyStimulus(3'b111, 32'd1, 32'd2, 5);
        applyStimulus(3'b100, 32'hFFFF_FFFF, 32'd1, 0);
        applyStimulus(3'b110, 32'h8000_0000, 32'h8000_0000, 0);

        resetMidRun();
        applyStimulus(3'b000, 32'd1, 32'd1, 0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(3'($urandom), $urandom, (i % 5 == 0) ? 32'd0 : $urandom,
                          int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_serial.md
ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 SHALL have parameter DIGIT_W, default 4, meaning bits processed per RUN cycle; legal values 1, 2, 4, 8, 16, 32.
REQ-002 SHALL have parameter N derived as 32/DIGIT_W, meaning RUN cycles per operation; not user-overridable.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 alu_control  input  3  operation code: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-008 src_a  input  32  operand A.
REQ-009 src_b  input  32  operand B.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 alu_result  output  32  registered result.
REQ-013 zero  output  1  registered flag, 1 when alu_result == 0.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1 and out_valid=0; on in_valid=1, capture src_a, src_b and alu_control, clear the digit counter, and go to RUN.
REQ-016 RUN and DONE: in_ready=0; in_valid is ignored and the captured operands are not disturbed.
REQ-017 RUN: each cycle processes digit k (bits k*DIGIT_W+DIGIT_W-1 down to k*DIGIT_W), LSB digit first, then increments k; after digit N-1, go to DONE.
REQ-018 Add SHALL use carry-in 0 on digit 0; sub and slt SHALL use bitwise-inverted B with carry-in 1 on digit 0; carry SHALL propagate digit to digit through a 1-bit register.
REQ-019 And and or SHALL be bitwise per digit, with no carry involvement.
REQ-020 Codes 100, 110 and 111 SHALL execute as add.
REQ-021 Slt SHALL produce {31'b0, lt}, where lt = s31 XOR ovf; s31 is difference bit 31, ovf = (a31 == ~b31) AND (s31 != a31), with all terms taken from the last digit.
REQ-022 Arithmetic SHALL be modulo 2^32; carry-out of bit 31 is discarded.
REQ-023 alu_result and zero SHALL update only on the RUN-to-DONE edge; they hold stable at all other times.
REQ-024 Latency: out_valid rises exactly N cycles after the accept edge (8 cycles at DIGIT_W=4).
REQ-025 DONE: out_valid=1; alu_result and zero hold stable while out_ready=0; on out_ready=1, go to IDLE.
REQ-026 A new request SHALL NOT be accepted in the same cycle a result is consumed; the minimum accept-to-accept spacing is N+2 cycles.
REQ-027 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-028 rst=1 SHALL force IDLE on the next edge from any state, including mid-RUN, abandoning the operation.
REQ-029 Reset values: out_valid=0, in_ready=1 (after the reset edge), alu_result=0, zero=1, digit counter=0, carry register=0.
REQ-030 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-031 add, A=5, B=7, out_ready=1 -> out_valid exactly 8 cycles after accept; alu_result=12, zero=0.
REQ-032 sub, A=3, B=3 -> alu_result=0, zero=1; sub, A=0, B=1 -> alu_result=0xFFFFFFFF.
REQ-033 slt, A=0xFFFFFFFF, B=1 -> alu_result=1; slt, A=0x7FFFFFFF, B=0x80000000 (overflow case) -> alu_result=0.
REQ-034 and, A=0xF0F0F0F0, B=0xFF00FF00 -> 0xF000F000; or with the same operands -> 0xFFF0FFF0; code 111, A=1, B=2 -> 3.
REQ-035 Hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> out_valid, alu_result and zero stay stable, and in_ready stays 0; then pulse out_ready -> IDLE on the next cycle.
REQ-036 Assert rst in RUN at digit 3 -> next cycle in IDLE with out_valid=0, alu_result=0, zero=1; a subsequent add, A=1, B=1 -> 2 with normal latency.
